countdown_timer: RTL and testbench
==================================

# countdown_timer

Four-digit BCD MM:SS countdown timer for the CLOCK display path. It is the down-counting counterpart of the up-counting digit counters. The timer loads a BCD preset, decrements once per prescaled second with a borrow chain across the digits, and supports start, pause and resume. On reaching 00:00 it stops and flags expiry. Its digit outputs feed the same seven-segment display mux as the time-of-day digits.

## Interface
- CLK_DIV, default 50_000_000: clk cycles per one-second tick; legal values are ≥ 2.
- ALARM_SEC, default 5: alarm duration in ticks; used only when COUNTDOWN_ALARM_EN is defined.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- load  in  1  synchronous; loads `preset` and enters IDLE.
- start  in  1  level-sampled each cycle; starts or resumes the countdown.
- pause  in  1  level-sampled each cycle; pauses the countdown.
- preset  in  16  BCD value {min_tens, min_ones, sec_tens, sec_ones}, 4 bits per digit.
- digits  out  16  current BCD value, same packing as `preset`.
- running  out  1  high while in RUN.
- done  out  1  one-cycle pulse on expiry.
- alarm  out  1  expiry alarm; see Configuration.

## Operation
- Reset values: digits = 16'h0000, state = IDLE, prescaler = 0, running = 0, done = 0, alarm = 0.
- Preset sanitising on load: each ones digit above 9 is clamped to 9, and each tens digit above 5 is clamped to 5.
- FSM states are IDLE, RUN, PAUSE and EXPIRED.
  - load in any state → IDLE, digits ← sanitised preset, prescaler ← 0. load has priority over everything else.
  - IDLE + start + !pause + digits ≠ 0 → RUN, prescaler ← 0. start is ignored when digits = 0.
  - RUN + pause → PAUSE. The prescaler holds its value, so the partial second is preserved. pause wins over start.
  - PAUSE + start + !pause → RUN, and the prescaler resumes from its held value.
  - RUN: prescaler counts 0 … CLK_DIV-1 and wraps to 0. A tick fires in the cycle where prescaler = CLK_DIV-1.
  - On each tick the time is decremented as follows:
    - sec_ones decrements. If it was 0, it becomes 9 and borrows from sec_tens.
    - sec_tens: 0 becomes 5 and borrows from min_ones.
    - min_ones: 0 becomes 9 and borrows from min_tens.
    - min_tens decrements on borrow.
  - When the decremented value is 0000, the state goes to EXPIRED on the same edge.
  - EXPIRED: digits hold 0000 and start/pause are ignored. Only load or reset leaves this state.
- Outputs are registered. `running` is 1 exactly when state = RUN.

## Timing
- First decrement occurs CLK_DIV cycles after the edge that samples start in IDLE.
- Subsequent decrements occur every CLK_DIV cycles while in RUN. Cycles spent in PAUSE do not count toward a tick.
- The sec_ones wrap, borrow and expiry all happen on a single edge. There is no multi-cycle ripple.
- done is high for exactly the one cycle in which digits first read 0000. It does not re-fire while the timer stays in EXPIRED.
- load arriving on a tick edge: load wins and the decrement is discarded.
- Reset asserted mid-count: all state returns to reset values immediately, without waiting for a clock edge.

## Configuration
- Macro: COUNTDOWN_ALARM_EN.
- Defined:
  - alarm rises together with done.
  - alarm stays high for ALARM_SEC ticks. While in EXPIRED, the prescaler keeps running to time these ticks.
  - alarm falls early on load or reset.
  - The alarm tick counter is wide enough for ALARM_SEC.
- Undefined:
  - alarm is tied to 0.
  - The prescaler is held at 0 in EXPIRED.
  - No alarm counter logic is synthesised.

## Test plan
- Reset and load: release reset, then load 16'h0105 → digits = 0105, running = 0, done = 0.
- Borrow chain (CLK_DIV = 4): load 1000, start; after 1 tick (4 cycles) → digits = 0959; after 600 ticks → digits = 0000, done pulses once, state = EXPIRED.
- Pause/resume (CLK_DIV = 4): load 0003, start; pause 2 cycles into the second second; hold for 20 cycles; resume → the next decrement lands 2 cycles after resume; after 3 ticks total → 0000 with done.
- Clamping and zero start: load 16'hFA7C → digits = 5959. Load 0000 and start → stays IDLE, running = 0.
- Priority: start = pause = 1 in RUN → PAUSE. load asserted on a tick edge → digits = sanitised preset, no decrement.
- Alarm (COUNTDOWN_ALARM_EN defined, ALARM_SEC = 2, CLK_DIV = 4): run 0001 to expiry → alarm high for 8 cycles, then low. Repeat with load 1 cycle after done → alarm drops on the next edge. With the macro undefined, alarm = 0 throughout.

Source files
------------

// File: rtl/countdown_timer.sv
// countdown_timer: four-digit BCD MM:SS down-counter with start/pause/resume
// and an expiry pulse. Digits feed the shared seven-segment display mux.
// Optional feature macro: COUNTDOWN_ALARM_EN (timed alarm after expiry).
`timescale 1ns/1ps

module countdown_timer #(
    parameter int unsigned CLK_DIV   = 50_000_000,
    parameter int unsigned ALARM_SEC = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        start,
    input  logic        pause,
    input  logic [15:0] preset,
    output logic [15:0] digits,
    output logic        running,
    output logic        done,
    output logic        alarm
);

    localparam int unsigned PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    // Elaboration-time guard on illegal parameter values.
    if (CLK_DIV < 2 || ALARM_SEC < 1) begin : g_param_check
        $error("countdown_timer: CLK_DIV must be >= 2 and ALARM_SEC >= 1");
    end

    // Clamp ones digits to 9 and tens digits to 5.
    function automatic logic [15:0] sanitise(input logic [15:0] p);
        logic [15:0] r;
        r[15:12] = (p[15:12] > 4'd5) ? 4'd5 : p[15:12];
        r[11:8]  = (p[11:8]  > 4'd9) ? 4'd9 : p[11:8];
        r[7:4]   = (p[7:4]   > 4'd5) ? 4'd5 : p[7:4];
        r[3:0]   = (p[3:0]   > 4'd9) ? 4'd9 : p[3:0];
        return r;
    endfunction

    // Single-edge BCD decrement with borrow through all four digits.
    function automatic logic [15:0] decrement(input logic [15:0] v);
        logic [3:0] mt, mo, st, so;
        logic       b;
        {mt, mo, st, so} = v;
        b  = (so == 4'd0);
        so = b ? 4'd9 : so - 4'd1;
        if (b) begin
            b  = (st == 4'd0);
            st = b ? 4'd5 : st - 4'd1;
        end
        if (b) begin
            b  = (mo == 4'd0);
            mo = b ? 4'd9 : mo - 4'd1;
        end
        if (b) begin
            mt = mt - 4'd1;
        end
        return {mt, mo, st, so};
    endfunction

    state_t        state_q, state_d;
    logic [15:0]   digits_q, digits_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          running_q, running_d;
    logic          done_q, done_d;
    logic          tick_c;
    logic [15:0]   dec_c;

`ifdef COUNTDOWN_ALARM_EN
    localparam int unsigned ACW = (ALARM_SEC > 1) ? $clog2(ALARM_SEC + 1) : 1;
    logic           alarm_q, alarm_d;
    logic [ACW-1:0] acnt_q, acnt_d;
`endif

    assign tick_c = (presc_q == PW'(CLK_DIV - 1));
    assign dec_c  = decrement(digits_q);

    // Next-state, prescaler and output computation.
    always_comb begin
        state_d  = state_q;
        digits_d = digits_q;
        presc_d  = presc_q;
        done_d   = 1'b0;
`ifdef COUNTDOWN_ALARM_EN
        alarm_d  = alarm_q;
        acnt_d   = acnt_q;
`endif
        if (load) begin
            state_d  = IDLE;
            digits_d = sanitise(preset);
            presc_d  = '0;
`ifdef COUNTDOWN_ALARM_EN
            alarm_d  = 1'b0;
            acnt_d   = '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !pause && digits_q != 16'h0000) begin
                        state_d = RUN;
                        presc_d = '0;
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_d = PAUSE;
                    end else if (tick_c) begin
                        presc_d  = '0;
                        digits_d = dec_c;
                        if (dec_c == 16'h0000) begin
                            state_d = EXPIRED;
                            done_d  = 1'b1;
`ifdef COUNTDOWN_ALARM_EN
                            alarm_d = 1'b1;
                            acnt_d  = '0;
`endif
                        end
                    end else begin
                        presc_d = PW'(presc_q + 1'b1);
                    end
                end
                PAUSE: begin
                    if (start && !pause) begin
                        state_d = RUN;
                    end
                end
                EXPIRED: begin
`ifdef COUNTDOWN_ALARM_EN
                    if (alarm_q) begin
                        if (tick_c) begin
                            presc_d = '0;
                            if (acnt_q == ACW'(ALARM_SEC - 1)) begin
                                alarm_d = 1'b0;
                            end else begin
                                acnt_d = ACW'(acnt_q + 1'b1);
                            end
                        end else begin
                            presc_d = PW'(presc_q + 1'b1);
                        end
                    end else begin
                        presc_d = '0;
                    end
`else
                    presc_d = '0;
`endif
                end
                default: state_d = IDLE;
            endcase
        end
        running_d = (state_d == RUN);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            digits_q  <= 16'h0000;
            presc_q   <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef COUNTDOWN_ALARM_EN
            alarm_q   <= 1'b0;
            acnt_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            digits_q  <= digits_d;
            presc_q   <= presc_d;
            running_q <= running_d;
            done_q    <= done_d;
`ifdef COUNTDOWN_ALARM_EN
            alarm_q   <= alarm_d;
            acnt_q    <= acnt_d;
`endif
        end
    end

    assign digits  = digits_q;
    assign running = running_q;
    assign done    = done_q;
`ifdef COUNTDOWN_ALARM_EN
    assign alarm   = alarm_q;
`else
    assign alarm   = 1'b0;
`endif

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed test-plan scenarios plus random stimulus,
// checked every cycle against a seconds-based reference model.
`timescale 1ns/1ps

module tb_countdown_timer;

    localparam int CLK_DIV   = 4;
    localparam int ALARM_SEC = 2;
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_EXP = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load = 1'b0, start = 1'b0, pause = 1'b0;
    logic [15:0] preset = 16'h0000;
    logic [15:0] digits;
    logic        running, done, alarm;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: remaining time in whole seconds.
    int m_state, m_secs, m_cnt, m_aticks;
    bit m_done, m_alarm;

    countdown_timer #(.CLK_DIV(CLK_DIV), .ALARM_SEC(ALARM_SEC)) dut (
        .clk(clk), .rst(rst), .load(load), .start(start), .pause(pause),
        .preset(preset), .digits(digits), .running(running), .done(done),
        .alarm(alarm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int preset_secs(input logic [15:0] p);
        return min_i(int'(p[15:12]), 5) * 600 + min_i(int'(p[11:8]), 9) * 60 +
               min_i(int'(p[7:4]), 5) * 10 + min_i(int'(p[3:0]), 9);
    endfunction

    function automatic logic [15:0] secs_bcd(input int s);
        return {4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
    endfunction

    task automatic model_reset();
        m_state = S_IDLE; m_secs = 0; m_cnt = 0; m_aticks = 0;
        m_done = 0; m_alarm = 0;
    endtask

    // One clock edge of the reference model, using the currently driven inputs.
    task automatic model_step();
        m_done = 0;
        if (load) begin
            m_state = S_IDLE; m_secs = preset_secs(preset); m_cnt = 0; m_alarm = 0;
        end else begin
            case (m_state)
                S_IDLE: if (start && !pause && m_secs != 0) begin
                    m_state = S_RUN; m_cnt = 0;
                end
                S_RUN: if (pause) m_state = S_PAUSE;
                else begin
                    m_cnt++;
                    if (m_cnt == CLK_DIV) begin
                        m_cnt = 0;
                        m_secs--;
                        if (m_secs == 0) begin
                            m_state = S_EXP; m_done = 1;
`ifdef COUNTDOWN_ALARM_EN
                            m_alarm = 1; m_aticks = 0;
`endif
                        end
                    end
                end
                S_PAUSE: if (start && !pause) m_state = S_RUN;
                default: begin
                    if (m_alarm) begin
                        m_cnt++;
                        if (m_cnt == CLK_DIV) begin
                            m_cnt = 0; m_aticks++;
                            if (m_aticks == ALARM_SEC) m_alarm = 0;
                        end
                    end
                end
            endcase
        end
    endtask

    task automatic compare_all();
        chk("digits",  digits,  secs_bcd(m_secs));
        chk("running", 16'(running), 16'(m_state == S_RUN));
        chk("done",    16'(done),    16'(m_done));
        chk("alarm",   16'(alarm),   16'(m_alarm));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic do_load(input logic [15:0] p);
        preset = p; load = 1'b1; cycle(); load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1; cycle(); start = 1'b0;
    endtask

    task automatic run_until_done(input int budget);
        int c = 0;
        while (!done && c < budget) begin cycle(); c++; end
        chk("done_timeout", 16'(c < budget), 16'd1);
    endtask

    initial begin
        int n;
        model_reset();
        #1;
        chk("rst_digits", digits, 16'h0000);
        chk("rst_running", 16'(running), 16'd0);
        chk("rst_done", 16'(done), 16'd0);
        chk("rst_alarm", 16'(alarm), 16'd0);
        @(negedge clk); rst = 1'b1;

        // Reset and load
        do_load(16'h0105);
        chk("load_0105", digits, 16'h0105);

        // Borrow chain 10:00 -> 09:59 -> ... -> 00:00
        do_load(16'h1000);
        do_start();
        repeat (CLK_DIV) cycle();
        chk("borrow_0959", digits, 16'h0959);
        run_until_done(700 * CLK_DIV);
        chk("borrow_zero", digits, 16'h0000);
        repeat (3) begin cycle(); chk("done_once", 16'(done), 16'd0); end

        // Pause two counting cycles into the second second, then resume
        do_load(16'h0003);
        do_start();
        repeat (CLK_DIV + 2) cycle();
        pause = 1'b1; cycle(); pause = 1'b0;
        chk("paused_run", 16'(running), 16'd0);
        repeat (20) cycle();
        chk("pause_hold", digits, 16'h0002);
        do_start();
        cycle();
        chk("resume_r1", digits, 16'h0002);
        cycle();
        chk("resume_r2", digits, 16'h0001);
        run_until_done(4 * CLK_DIV);
        chk("pause_zero", digits, 16'h0000);

        // Clamping and zero start
        do_load(16'hFA7C);
        chk("clamp", digits, 16'h5959);
        do_load(16'h0000);
        do_start();
        chk("zero_start", 16'(running), 16'd0);

        // Priority: pause over start, load over tick
        do_load(16'h0010);
        do_start();
        cycle();
        start = 1'b1; pause = 1'b1; cycle(); start = 1'b0; pause = 1'b0;
        chk("pause_wins", 16'(running), 16'd0);
        do_start();
        n = 0;
        while (!(m_state == S_RUN && m_cnt == CLK_DIV - 1) && n < 2 * CLK_DIV) begin cycle(); n++; end
        do_load(16'h0042);
        chk("load_on_tick", digits, 16'h0042);

        // Alarm duration after expiry
        do_load(16'h0001);
        do_start();
        run_until_done(3 * CLK_DIV);
        n = 0;
        while (alarm && n < 50) begin n++; cycle(); end
`ifdef COUNTDOWN_ALARM_EN
        chk("alarm_len", 16'(n), 16'(ALARM_SEC * CLK_DIV));
`else
        chk("alarm_len", 16'(n), 16'd0);
`endif
        do_load(16'h0001);
        do_start();
        run_until_done(3 * CLK_DIV);
        do_load(16'h0001);
        chk("alarm_drop", 16'(alarm), 16'd0);

        // Asynchronous reset mid-count
        do_load(16'h0030);
        do_start();
        repeat (5) cycle();
        @(negedge clk); #2 rst = 1'b0; #1;
        model_reset();
        chk("async_digits", digits, 16'h0000);
        chk("async_running", 16'(running), 16'd0);
        @(negedge clk); rst = 1'b1;

        // Random stimulus against the model
        for (int i = 0; i < 4000; i++) begin
            load  = ($urandom_range(0, 59) == 0);
            start = ($urandom_range(0, 3) == 0);
            pause = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 7) == 0) preset = 16'($urandom);
            else preset = {8'h00, 4'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
            cycle();
        end
        load = 1'b0; start = 1'b0; pause = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
